// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF sync, false-start reject, parity/frame/overrun flags.
// rx_valid 1 clk after last stop-bit centre; word held until rx_ready, a frame completing while held is dropped.
module uart_rx_cfg #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int          CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] CYC_LAST  = 16'(CYCLE - 1);
    localparam logic [15:0] HALF_LAST = 16'(CYCLE / 2 - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic        ODD_MODE  = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rxs_q;
    logic [15:0]            cnt_q, cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   pe_q, pe_d, fe_q, fe_d;
    logic                   ovr_q, ovr_d;
    logic                   bit_tick, done;

    assign bit_tick = (cnt_q == CYC_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shifting in at the top leaves it at bit 0
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) state_d = (PARITY != 0) ? PAR : STOP;
                    else                       bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PAR: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    perr_d  = (^{shift_q, rxs_q}) != ODD_MODE;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (!rxs_q) ferr_d = 1'b1;
                    if (stop_cnt_q == STOP_LAST) begin
                        done    = 1'b1;
                        // a low stop bit may be a break: wait for the line to idle before re-arming
                        state_d = ferr_d ? WAIT_IDLE : IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = 1'b0;
        if (done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                pe_d    = perr_d;
                fe_d    = ferr_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx_pin;
            rxs_q      <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = pe_q;
    assign frame_err   = fe_q;
    assign overrun_err = ovr_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) at CYCLE=10, scoreboarded per instance.
// Expected words are queued as frames are driven and popped when each receiver hands a word over.
module tb_uart_rx_cfg;
    localparam int CYC = 10;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx;
    logic [2:0] rdy;

    logic [7:0] d0, d2;
    logic [6:0] d1;
    logic [2:0] vld, pe, fe, ov, bsy;

    exp_t q0[$], q1[$], q2[$];
    int   ovc[3];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx[0]), .rx_ready(rdy[0]), .rx_data(d0), .rx_valid(vld[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun_err(ov[0]), .busy(bsy[0]));
    uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx[1]), .rx_ready(rdy[1]), .rx_data(d1), .rx_valid(vld[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun_err(ov[1]), .busy(bsy[1]));
    uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx[2]), .rx_ready(rdy[2]), .rx_data(d2), .rx_valid(vld[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun_err(ov[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int inst, input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.d  = d;
        e.pe = p;
        e.fe = f;
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int inst);
        case (inst)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic mon(input int inst, input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        int   sz;
        sz = qsize(inst);
        check($sformatf("u%0d_word_expected", inst), 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            case (inst)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("u%0d_data", inst), 32'(d), 32'(e.d));
            check($sformatf("u%0d_parity_err", inst), 32'(p), 32'(e.pe));
            check($sformatf("u%0d_frame_err", inst), 32'(f), 32'(e.fe));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && vld[0] && rdy[0]) mon(0, {1'b0, d0}, pe[0], fe[0]);
        if (rst_n && vld[1] && rdy[1]) mon(1, {2'b0, d1}, pe[1], fe[1]);
        if (rst_n && vld[2] && rdy[2]) mon(2, {1'b0, d2}, pe[2], fe[2]);
        for (int i = 0; i < 3; i++) if (ov[i]) ovc[i]++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input int inst, input logic v);
        rx[inst] = v;
        tick(CYC);
    endtask

    // par < 0 means no parity bit; stops[0] goes out first
    task automatic send(input int inst, input logic [8:0] data, input int nbits,
                        input int par, input logic [1:0] stops, input int nstop);
        bit_out(inst, 1'b0);
        for (int i = 0; i < nbits; i++) bit_out(inst, data[i]);
        if (par >= 0) bit_out(inst, par[0]);
        for (int i = 0; i < nstop; i++) bit_out(inst, stops[i]);
        rx[inst] = 1'b1;
    endtask

    task automatic send_7e1(input logic [6:0] data, input int par);
        logic [7:0] all;
        all = {par[0], data};
        push(1, {2'b0, data}, ^all, 1'b0);
        send(1, {2'b0, data}, 7, par, 2'b11, 1);
    endtask

    initial begin
        logic [7:0] b2b [4];
        b2b[0] = 8'h01; b2b[1] = 8'h80; b2b[2] = 8'hFF; b2b[3] = 8'h5A;
        for (int i = 0; i < 3; i++) ovc[i] = 0;
        rst_n = 1'b0;
        rx    = 3'b111;
        rdy   = 3'b111;
        tick(3);
        check("rst_data", 32'(d0), 32'd0);
        check("rst_valid", 32'(vld), 32'd0);
        check("rst_errs", 32'({pe, fe, ov}), 32'd0);
        check("rst_busy", 32'(bsy), 32'd0);
        rst_n = 1'b1;
        tick(3);

        push(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, -1, 2'b11, 1);
        tick(2);
        check("a5_drained", 32'(qsize(0)), 32'd0);
        check("a5_valid_low", 32'(vld[0]), 32'd0);
        check("a5_idle", 32'(bsy[0]), 32'd0);

        send_7e1(7'h55, 0);
        send_7e1(7'h55, 1);
        send_7e1(7'h01, 0);
        tick(2);
        check("par_drained", 32'(qsize(1)), 32'd0);

        rdy[0] = 1'b0;
        push(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, -1, 2'b11, 1);
        send(0, 9'h022, 8, -1, 2'b11, 1);
        tick(2);
        check("ovr_hold_data", 32'(d0), 32'h11);
        check("ovr_hold_valid", 32'(vld[0]), 32'd1);
        check("ovr_pulses", 32'(ovc[0]), 32'd1);
        rdy[0] = 1'b1;
        tick(1);
        check("ovr_valid_drop", 32'(vld[0]), 32'd0);
        check("ovr_drained", 32'(qsize(0)), 32'd0);

        rx[0] = 1'b0;
        tick(3);
        rx[0] = 1'b1;
        tick(3);
        check("fs_busy_mid", 32'(bsy[0]), 32'd1);
        tick(5);
        check("fs_busy_low", 32'(bsy[0]), 32'd0);
        check("fs_no_word", 32'(vld[0]), 32'd0);

        push(0, 9'h000, 1'b0, 1'b1);
        rx[0] = 1'b0;
        tick(30 * CYC);
        check("brk_wait_busy", 32'(bsy[0]), 32'd1);
        rx[0] = 1'b1;
        tick(3 * CYC);
        check("brk_drained", 32'(qsize(0)), 32'd0);
        check("brk_idle", 32'(bsy[0]), 32'd0);
        push(0, 9'h096, 1'b0, 1'b0);
        send(0, 9'h096, 8, -1, 2'b11, 1);
        tick(2);
        check("brk_rearm", 32'(qsize(0)), 32'd0);

        push(2, 9'h03C, 1'b0, 1'b1);
        send(2, 9'h03C, 8, -1, 2'b01, 2);
        tick(CYC);
        for (int i = 0; i < 4; i++) begin
            push(2, {1'b0, b2b[i]}, 1'b0, 1'b0);
            send(2, {1'b0, b2b[i]}, 8, -1, 2'b11, 2);
        end
        tick(2);
        check("b2b_drained", 32'(qsize(2)), 32'd0);

        bit_out(0, 1'b0);
        for (int i = 0; i < 4; i++) bit_out(0, b2b[3][i]);
        check("mr_busy_before", 32'(bsy[0]), 32'd1);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        #1;
        check("mr_busy", 32'(bsy[0]), 32'd0);
        check("mr_data", 32'(d0), 32'd0);
        check("mr_flags", 32'({vld[0], pe[0], fe[0], ov[0]}), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        push(0, 9'h0C3, 1'b0, 1'b0);
        send(0, 9'h0C3, 8, -1, 2'b11, 1);
        tick(2 * CYC);
        check("mr_drained", 32'(qsize(0)), 32'd0);
        check("no_ovr_u1", 32'(ovc[1]), 32'd0);
        check("no_ovr_u2", 32'(ovc[2]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
